// File: rtl/store_pkg.sv
// Shared definitions for the store write queue: opcodes, byte-lane indices
// and the queued entry layout.
package store_pkg;

   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;

   // Big-endian lanes: write-enable bit index selected by each byte offset.
   localparam int LANE_OFF0 = 3;
   localparam int LANE_OFF1 = 2;
   localparam int LANE_OFF2 = 1;
   localparam int LANE_OFF3 = 0;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  we;
   } store_entry_t;

   // One-hot byte enable for a byte offset within the word.
   function automatic logic [3:0] byte_we(input logic [1:0] off);
      logic [3:0] we;
      we = 4'b0000;
      case (off)
         2'b00:   we[LANE_OFF0] = 1'b1;
         2'b01:   we[LANE_OFF1] = 1'b1;
         2'b10:   we[LANE_OFF2] = 1'b1;
         default: we[LANE_OFF3] = 1'b1;
      endcase
      return we;
   endfunction

endpackage

// File: rtl/store_aligner.sv
// Turns a raw store (opcode, byte address, low-justified data) into a
// lane-aligned queue entry and flags misalignment.
module store_aligner
   import store_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [31:0]  addr,
   input  logic [31:0]  wdata,
   output logic         is_store,
   output logic         misaligned,
   output store_entry_t entry
);

   // Replicate the operand across lanes and pick the byte enables.
   always_comb begin
      is_store   = 1'b0;
      misaligned = 1'b0;
      entry.addr = addr[31:2];
      entry.data = wdata;
      entry.we   = 4'b0000;
      case (opcode)
         OP_SB: begin
            is_store   = 1'b1;
            entry.data = {4{wdata[7:0]}};
            entry.we   = byte_we(addr[1:0]);
         end
         OP_SH: begin
            is_store   = 1'b1;
            misaligned = addr[0];
            entry.data = {2{wdata[15:0]}};
            entry.we   = addr[1] ? 4'b0011 : 4'b1100;
         end
         OP_SW: begin
            is_store   = 1'b1;
            misaligned = (addr[1:0] != 2'b00);
            entry.data = wdata;
            entry.we   = 4'b1111;
         end
         default: begin
            is_store = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_write_queue.sv
// In-order store buffer between the pipeline and data memory. Stores are
// aligned on entry, issued strictly FIFO, and the queued word addresses are
// compared against the in-flight load for hazard detection.
module store_write_queue
   import store_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        StoreValid,
   output logic        StoreReady,
   input  logic [5:0]  opcodeM,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] WriteDataM,
   output logic        MemValid,
   input  logic        MemReady,
   output logic [29:0] MemAddr,
   output logic [31:0] MemData,
   output logic [3:0]  MemWE,
   input  logic [31:0] LoadAddr,
   output logic        LoadHazard,
   output logic        ErrMisaligned
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic           err_q, err_d;
   store_entry_t   mem_q [DEPTH];
   store_entry_t   mem_d [DEPTH];

   logic           is_store;
   logic           misaligned;
   store_entry_t   new_entry;
   store_entry_t   head;
   logic           push;
   logic           pop;
   logic           unused_load_bits;

   store_aligner u_aligner (
      .opcode     (opcodeM),
      .addr       (ALUoutM),
      .wdata      (WriteDataM),
      .is_store   (is_store),
      .misaligned (misaligned),
      .entry      (new_entry)
   );

   // Only the word address of the load matters for the hazard compare.
   assign unused_load_bits = ^LoadAddr[1:0];

   assign StoreReady = (count_q != FULL_CNT);
   assign MemValid   = (count_q != '0);
   assign head       = mem_q[rd_ptr_q];
   // Outputs are zeroed when empty so reset shows clean values immediately.
   assign MemAddr    = MemValid ? head.addr : '0;
   assign MemData    = MemValid ? head.data : '0;
   assign MemWE      = MemValid ? head.we   : '0;
   assign ErrMisaligned = err_q;

   assign push = StoreValid & StoreReady & is_store & ~misaligned;
   assign pop  = MemValid & MemReady;

   // Next-state for pointers, count, valid bits, storage and error pulse.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      mem_d    = mem_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      err_d    = StoreValid & is_store & misaligned;
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (push) begin
         mem_d[wr_ptr_q] = new_entry;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
   end

   // Control state, cleared asynchronously so queued stores are discarded.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
      end
   end

   // Entry payload; meaningless unless the matching valid bit is set.
   always_ff @(posedge Clock) begin
      mem_q <= mem_d;
   end

   // Any resident entry (including one popping now) to the load's word.
   always_comb begin
      LoadHazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (mem_q[i].addr == LoadAddr[31:2])) begin
            LoadHazard = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_write_queue.sv
`timescale 1ns/1ps
module tb_store_write_queue;

   localparam logic [5:0] SB = 6'b101000;
   localparam logic [5:0] SH = 6'b101001;
   localparam logic [5:0] SW = 6'b101011;
   localparam logic [5:0] LW = 6'b100011;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        StoreValid;
   logic        StoreReady;
   logic [5:0]  opcodeM;
   logic [31:0] ALUoutM;
   logic [31:0] WriteDataM;
   logic        MemValid;
   logic        MemReady;
   logic [29:0] MemAddr;
   logic [31:0] MemData;
   logic [3:0]  MemWE;
   logic [31:0] LoadAddr;
   logic        LoadHazard;
   logic        ErrMisaligned;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [29:0] a;
      logic [31:0] d;
      logic [3:0]  w;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      bit          acc;
      bit          err;
      logic [29:0] eaddr;
      logic [31:0] edata;
      logic [3:0]  ewe;
   } vec_t;
   vec_t vecs[12];

   store_write_queue #(.DEPTH(4)) dut (
      .Clock(Clock), .Reset(Reset), .StoreValid(StoreValid), .StoreReady(StoreReady),
      .opcodeM(opcodeM), .ALUoutM(ALUoutM), .WriteDataM(WriteDataM),
      .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
      .MemWE(MemWE), .LoadAddr(LoadAddr), .LoadHazard(LoadHazard), .ErrMisaligned(ErrMisaligned)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      StoreValid = 1'b1;
      opcodeM    = op;
      ALUoutM    = a;
      WriteDataM = d;
   endtask

   // Push an SW to the scoreboard if the bench model says there is room.
   task automatic push_sw(input logic [31:0] a, input logic [31:0] d);
      drive(SW, a, d);
      chk("ready_before_push", StoreReady, (sb.size() != 4));
      if (sb.size() != 4) sb.push_back('{a: a[31:2], d: d, w: 4'b1111});
      step();
      StoreValid = 1'b0;
   endtask

   // Scoreboard: every accepted memory transaction must match the oldest expected store.
   always @(negedge Clock) begin
      if (!Reset && MemValid === 1'b1 && MemReady === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue actual addr=%h required none", MemAddr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("issue_addr", MemAddr, e.a);
            chk("issue_data", MemData, e.d);
            chk("issue_we",   MemWE,   e.w);
         end
      end
   end

   initial begin
      vecs[0]  = '{SB, 32'h0000_0101, 32'h0000_00AB, 1, 0, 30'h40,       32'hABAB_ABAB, 4'b0100};
      vecs[1]  = '{SB, 32'h0000_0100, 32'h1234_56CD, 1, 0, 30'h40,       32'hCDCD_CDCD, 4'b1000};
      vecs[2]  = '{SB, 32'h0000_0103, 32'h0000_007F, 1, 0, 30'h40,       32'h7F7F_7F7F, 4'b0001};
      vecs[3]  = '{SB, 32'h0000_0002, 32'hFFFF_FF11, 1, 0, 30'h0,        32'h1111_1111, 4'b0010};
      vecs[4]  = '{SH, 32'h0000_0006, 32'h0000_1234, 1, 0, 30'h1,        32'h1234_1234, 4'b0011};
      vecs[5]  = '{SH, 32'h0000_0008, 32'hABCD_5678, 1, 0, 30'h2,        32'h5678_5678, 4'b1100};
      vecs[6]  = '{SH, 32'h0000_0005, 32'h0000_1234, 0, 1, 30'h0,        32'h0,         4'b0000};
      vecs[7]  = '{SW, 32'h0000_0002, 32'h1111_2222, 0, 1, 30'h0,        32'h0,         4'b0000};
      vecs[8]  = '{SW, 32'h1000_0004, 32'hDEAD_BEEF, 1, 0, 30'h0400_0001, 32'hDEAD_BEEF, 4'b1111};
      vecs[9]  = '{LW, 32'h0000_0000, 32'h5555_5555, 0, 0, 30'h0,        32'h0,         4'b0000};
      vecs[10] = '{6'b000000, 32'h0000_0003, 32'h1, 0, 0, 30'h0,         32'h0,         4'b0000};
      vecs[11] = '{SW, 32'hFFFF_FFFC, 32'h0102_0304, 1, 0, 30'h3FFF_FFFF, 32'h0102_0304, 4'b1111};

      Reset = 1'b1; StoreValid = 1'b0; opcodeM = '0; ALUoutM = '0; WriteDataM = '0;
      MemReady = 1'b0; LoadAddr = 32'h0;
      step();
      step();
      chk("rst_memvalid", MemValid, 0);
      chk("rst_memaddr", MemAddr, 0);
      chk("rst_memdata", MemData, 0);
      chk("rst_memwe", MemWE, 0);
      chk("rst_err", ErrMisaligned, 0);
      chk("rst_hazard", LoadHazard, 0);
      chk("rst_ready", StoreReady, 1);
      Reset = 1'b0;
      step();

      // Table-driven single stores with memory always ready.
      MemReady = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].op, vecs[i].addr, vecs[i].data);
         chk($sformatf("v%0d_ready", i), StoreReady, 1);
         if (vecs[i].acc) sb.push_back('{a: vecs[i].eaddr, d: vecs[i].edata, w: vecs[i].ewe});
         step();
         StoreValid = 1'b0;
         chk($sformatf("v%0d_err", i), ErrMisaligned, vecs[i].err);
         chk($sformatf("v%0d_valid", i), MemValid, vecs[i].acc);
         step();
         chk($sformatf("v%0d_err_clr", i), ErrMisaligned, 0);
         chk($sformatf("v%0d_drained", i), MemValid, 0);
      end
      chk("sb_empty_vecs", sb.size(), 0);

      // Fill to full with memory stalled, reject a fifth, then drain in order.
      MemReady = 1'b0;
      for (int i = 0; i < 4; i++) push_sw(32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
      chk("full_ready", StoreReady, 0);
      chk("full_hold_addr", MemAddr, 30'h4);
      drive(SW, 32'h30, 32'hBAD0);
      step();
      StoreValid = 1'b0;
      chk("full_still", StoreReady, 0);
      chk("stall_hold_data", MemData, 32'hA0);
      MemReady = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("drain_empty", MemValid, 0);
      chk("sb_empty_drain", sb.size(), 0);

      // Full queue with simultaneous push and pop: push rejected, head advances.
      MemReady = 1'b0;
      for (int i = 0; i < 4; i++) push_sw(32'h50 + 32'(4 * i), 32'hC0 + 32'(i));
      drive(SW, 32'h60, 32'hBAD1);
      MemReady = 1'b1;
      chk("pp_ready", StoreReady, 0);
      step();
      StoreValid = 1'b0;
      MemReady = 1'b0;
      chk("pp_ready_after", StoreReady, 1);
      chk("pp_head", MemAddr, 30'h15);
      chk("pp_sb", sb.size(), 3);
      MemReady = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("pp_empty", MemValid, 0);

      // Load hazard: entering store excluded, resident and popping entries included.
      MemReady = 1'b0;
      LoadAddr = 32'h20;
      drive(SW, 32'h20, 32'h0F0F_0F0F);
      #1;
      chk("hz_entering", LoadHazard, 0);
      sb.push_back('{a: 30'h8, d: 32'h0F0F_0F0F, w: 4'b1111});
      step();
      StoreValid = 1'b0;
      LoadAddr = 32'h23;
      #1;
      chk("hz_same_word", LoadHazard, 1);
      LoadAddr = 32'h24;
      #1;
      chk("hz_next_word", LoadHazard, 0);
      LoadAddr = 32'h20;
      MemReady = 1'b1;
      #1;
      chk("hz_popping", LoadHazard, 1);
      step();
      chk("hz_gone", LoadHazard, 0);

      // Short reset mid-operation discards everything.
      MemReady = 1'b0;
      for (int i = 0; i < 3; i++) push_sw(32'h70 + 32'(4 * i), 32'hE0 + 32'(i));
      LoadAddr = 32'h70;
      chk("pre_rst_valid", MemValid, 1);
      Reset = 1'b1;
      #0.5;
      chk("mid_rst_valid", MemValid, 0);
      chk("mid_rst_ready", StoreReady, 1);
      #0.5;
      Reset = 1'b0;
      sb.delete();
      #1;
      chk("post_rst_valid", MemValid, 0);
      chk("post_rst_hazard", LoadHazard, 0);
      chk("post_rst_addr", MemAddr, 0);
      MemReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_quiet", MemValid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
